// File: rtl/minmax_pkg.sv
// Shared types for the min/max reduction engine: FSM states, reduction mode
// and the bit positions inside the result status word.
package minmax_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic {
    MODE_MIN = 1'b0,
    MODE_MAX = 1'b1
  } mode_e;

  localparam int STATUS_W     = 5;
  localparam int STAT_INVALID = 4;

endpackage

// File: rtl/minmax_cmp.sv
// Combinational IEEE-style classifier and total-order comparator for a/b.
// Build option: define MINMAX_ZERO_SIGN_EN to order -0 strictly below +0.
module minmax_cmp
  import minmax_pkg::*;
#(
  parameter int SIGN_W = 1,
  parameter int EXPO_W = 8,
  parameter int MANT_W = 23,
  localparam int DATA_W = SIGN_W + EXPO_W + MANT_W
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              a_is_nan_o,
  output logic              a_is_snan_o,
  output logic              b_is_nan_o,
  output logic              a_lt_b_o,
  output logic              equal_o
);

  localparam int MAG_W = EXPO_W + MANT_W;

  logic              aSign, bSign;
  logic [EXPO_W-1:0] aExp, bExp;
  logic [MANT_W-1:0] aMant, bMant;
  logic [MAG_W-1:0]  aMag, bMag;
  logic              aZero, bZero;

  assign aSign = a_i[DATA_W-1];
  assign bSign = b_i[DATA_W-1];
  assign aExp  = a_i[MAG_W-1:MANT_W];
  assign bExp  = b_i[MAG_W-1:MANT_W];
  assign aMant = a_i[MANT_W-1:0];
  assign bMant = b_i[MANT_W-1:0];
  assign aMag  = a_i[MAG_W-1:0];
  assign bMag  = b_i[MAG_W-1:0];
  assign aZero = (aMag == '0);
  assign bZero = (bMag == '0);

  assign a_is_nan_o  = (&aExp) && (|aMant);
  assign a_is_snan_o = a_is_nan_o && !aMant[MANT_W-1];
  assign b_is_nan_o  = (&bExp) && (|bMant);

  // Exponent:mantissa is monotonic in magnitude, so one unsigned compare
  // suffices; for negatives the magnitude order flips.
  always_comb begin
    a_lt_b_o = 1'b0;
    equal_o  = 1'b0;
    if (aZero && bZero) begin
`ifdef MINMAX_ZERO_SIGN_EN
      a_lt_b_o = aSign && !bSign;
      equal_o  = (aSign == bSign);
`else
      equal_o  = 1'b1;
`endif
    end else if (aSign != bSign) begin
      a_lt_b_o = aSign;
    end else begin
      equal_o  = (aMag == bMag);
      a_lt_b_o = aSign ? (aMag > bMag) : (aMag < bMag);
    end
  end

endmodule

// File: rtl/minmax_reduce.sv
// Streaming min/max reduction with NaN handling, sticky invalid flag and
// length truncation at MAX_LEN. Honours MINMAX_ZERO_SIGN_EN via minmax_cmp.
module minmax_reduce
  import minmax_pkg::*;
#(
  parameter int SIGN_W  = 1,
  parameter int EXPO_W  = 8,
  parameter int MANT_W  = 23,
  parameter int MAX_LEN = 16,
  localparam int DATA_W = SIGN_W + EXPO_W + MANT_W,
  localparam int IDX_W  = $clog2(MAX_LEN)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                in_last,
  input  logic                in_mode,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic [IDX_W-1:0]    out_idx,
  output logic [STATUS_W-1:0] out_status,
  output logic                out_trunc
);

  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_LEN - 1);
  localparam logic [DATA_W-1:0] QNAN =
    {{SIGN_W{1'b0}}, {EXPO_W{1'b1}}, 1'b1, {(MANT_W-1){1'b0}}};

  state_e             state_q, state_d;
  mode_e              mode_q, mode_d;
  logic [DATA_W-1:0]  acc_q, acc_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               invalid_q, invalid_d;
  logic               trunc_q, trunc_d;

  logic inNan, inSnan, accNan, inLtAcc, inEqAcc, replaceAcc;

  minmax_cmp #(
    .SIGN_W(SIGN_W),
    .EXPO_W(EXPO_W),
    .MANT_W(MANT_W)
  ) u_cmp (
    .a_i        (in_data),
    .b_i        (acc_q),
    .a_is_nan_o (inNan),
    .a_is_snan_o(inSnan),
    .b_is_nan_o (accNan),
    .a_lt_b_o   (inLtAcc),
    .equal_o    (inEqAcc)
  );

  // Strict replacement keeps the lowest index on ties; NaNs lose to numbers.
  always_comb begin
    replaceAcc = 1'b0;
    if (accNan)                 replaceAcc = !inNan;
    else if (inNan)             replaceAcc = 1'b0;
    else if (mode_q == MODE_MIN) replaceAcc = inLtAcc;
    else                        replaceAcc = !inLtAcc && !inEqAcc;
  end

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    acc_d     = acc_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    invalid_d = invalid_q;
    trunc_d   = trunc_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          acc_d     = in_data;
          idx_d     = '0;
          cnt_d     = CNT_W'(1);
          mode_d    = mode_e'(in_mode);
          invalid_d = inSnan;
          trunc_d   = 1'b0;
          state_d   = in_last ? ST_DONE : ST_ACC;
        end
      end
      ST_ACC: begin
        if (in_valid) begin
          cnt_d     = cnt_q + CNT_W'(1);
          invalid_d = invalid_q | inSnan;
          if (replaceAcc) begin
            acc_d = in_data;
            idx_d = cnt_q[IDX_W-1:0];
          end
          if (in_last) begin
            state_d = ST_DONE;
          end else if (cnt_q == LAST_IDX) begin
            state_d = ST_DONE;
            trunc_d = 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_MIN;
      acc_q     <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      invalid_q <= 1'b0;
      trunc_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      acc_q     <= acc_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      invalid_q <= invalid_d;
      trunc_q   <= trunc_d;
    end
  end

  always_comb begin
    out_status               = '0;
    out_status[STAT_INVALID] = invalid_q;
  end

  assign in_ready  = (state_q != ST_DONE);
  assign out_valid = (state_q == ST_DONE);
  assign out_data  = accNan ? QNAN : acc_q;
  assign out_idx   = idx_q;
  assign out_trunc = trunc_q;

endmodule

// File: tb/tb_minmax_reduce.sv
// Self-checking bench for minmax_reduce: directed FP32 cases plus random
// streams scored against an ordering-key reference model.
module tb_minmax_reduce;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_last, in_mode;
  logic [31:0] in_data;
  logic        out_valid, out_ready, out_trunc;
  logic [31:0] out_data;
  logic [3:0]  out_idx;
  logic [4:0]  out_status;

  logic        in4Valid, in4Ready, in4Last, in4Mode;
  logic [31:0] in4Data;
  logic        out4Valid, out4Ready, out4Trunc;
  logic [31:0] out4Data;
  logic [1:0]  out4Idx;
  logic [4:0]  out4Status;

  int checks = 0;
  int errors = 0;

  logic [31:0] elems[$];
  logic        useLast;
  logic        modeBit;

  always #5 clk = ~clk;

  minmax_reduce dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_status(out_status), .out_trunc(out_trunc)
  );

  minmax_reduce #(.MAX_LEN(4)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in4Valid), .in_ready(in4Ready), .in_data(in4Data),
    .in_last(in4Last), .in_mode(in4Mode),
    .out_valid(out4Valid), .out_ready(out4Ready), .out_data(out4Data),
    .out_idx(out4Idx), .out_status(out4Status), .out_trunc(out4Trunc)
  );

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic bit isNan(input logic [31:0] x);
    return (x[30:23] == 8'hff) && (x[22:0] != 23'h0);
  endfunction

  function automatic bit isSnan(input logic [31:0] x);
    return isNan(x) && !x[22];
  endfunction

  // Numbers map onto a signed integer line; doubling leaves room for -0 at -1.
  function automatic longint keyOf(input logic [31:0] x);
    longint mag;
    mag = longint'(x[30:0]);
    if (x[31]) begin
`ifdef MINMAX_ZERO_SIGN_EN
      if (mag == 0) return -1;
`endif
      return -2 * mag;
    end
    return 2 * mag;
  endfunction

  function automatic void computeExpected(output logic [31:0] eData, output int eIdx,
                                          output logic eInv, output logic eTrunc);
    int best;
    best = -1;
    eInv = 1'b0;
    foreach (elems[i]) begin
      if (isSnan(elems[i])) eInv = 1'b1;
      if (!isNan(elems[i])) begin
        if (best < 0) best = i;
        else if (modeBit == 1'b0 ? keyOf(elems[i]) < keyOf(elems[best])
                                 : keyOf(elems[i]) > keyOf(elems[best])) best = i;
      end
    end
    if (best < 0) begin
      eData = 32'h7FC00000;
      eIdx  = 0;
    end else begin
      eData = elems[best];
      eIdx  = best;
    end
    eTrunc = !useLast;
  endfunction

  function automatic logic [31:0] randElem();
    logic [31:0] r;
    case ($urandom_range(0, 9))
      0: r = {1'($urandom), 31'h0};
      1: r = {1'($urandom), 8'hff, 23'h0};
      2: r = {1'($urandom), 8'hff, 1'b1, 22'($urandom)};
      3: r = {1'($urandom), 8'hff, 1'b0, 22'($urandom_range(1, 4194303))};
      4: r = (elems.size() > 0) ? elems[$urandom_range(0, elems.size() - 1)] : $urandom;
      5: r = {1'($urandom), 8'd127, 20'h0, 3'($urandom)};
      default: r = $urandom;
    endcase
    return r;
  endfunction

  task automatic applyStimulus(input string tag, input int hold, input bit gaps);
    logic [31:0] eData;
    int          eIdx;
    logic        eInv, eTrunc;
    computeExpected(eData, eIdx, eInv, eTrunc);
    @(negedge clk);
    checkVal({tag, "_idle_rdy"}, 32'(in_ready), 32'd1);
    for (int i = 0; i < elems.size(); i++) begin
      if (i > 0) begin
        @(negedge clk);
        checkVal({tag, "_busy_valid"}, 32'(out_valid), 32'd0);
        checkVal({tag, "_busy_rdy"}, 32'(in_ready), 32'd1);
      end
      if (gaps && i > 0 && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = elems[i];
      in_last  = useLast && (i == elems.size() - 1);
      in_mode  = (i == 0) ? modeBit : 1'($urandom);
    end
    @(negedge clk);
    in_valid  = (hold > 0);
    in_data   = $urandom;
    in_last   = 1'($urandom);
    out_ready = (hold == 0);
    checkOutput(tag, eData, eIdx, eInv, eTrunc);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      checkOutput({tag, "_hold"}, eData, eIdx, eInv, eTrunc);
      if (h == hold - 1) begin
        out_ready = 1'b1;
        in_valid  = 1'b0;
      end
    end
    @(negedge clk);
    checkVal({tag, "_rel_valid"}, 32'(out_valid), 32'd0);
    checkVal({tag, "_rel_rdy"}, 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] eData, input int eIdx,
                             input logic eInv, input logic eTrunc);
    checkVal({tag, "_valid"}, 32'(out_valid), 32'd1);
    checkVal({tag, "_rdy"}, 32'(in_ready), 32'd0);
    checkVal({tag, "_data"}, out_data, eData);
    checkVal({tag, "_idx"}, 32'(out_idx), 32'(eIdx));
    checkVal({tag, "_status"}, 32'(out_status), 32'({eInv, 4'b0000}));
    checkVal({tag, "_trunc"}, 32'(out_trunc), 32'(eTrunc));
  endtask

  task automatic checkResetState(input string tag);
    checkVal({tag, "_valid"}, 32'(out_valid), 32'd0);
    checkVal({tag, "_rdy"}, 32'(in_ready), 32'd1);
    checkVal({tag, "_data"}, out_data, 32'h0);
    checkVal({tag, "_idx"}, 32'(out_idx), 32'd0);
    checkVal({tag, "_status"}, 32'(out_status), 32'd0);
    checkVal({tag, "_trunc"}, 32'(out_trunc), 32'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_mode = 1'b0; in_data = '0; out_ready = 1'b1;
    in4Valid = 1'b0; in4Last = 1'b0; in4Mode = 1'b0; in4Data = '0; out4Ready = 1'b0;
    repeat (2) @(negedge clk);
    checkResetState("reset");
    rst = 1'b0;

    elems = '{32'h40400000, 32'hBFC00000, 32'h40000000}; useLast = 1; modeBit = 0;
    applyStimulus("min3", 0, 0);
    elems = '{32'h7FA00000, 32'h3F800000}; useLast = 1; modeBit = 1;
    applyStimulus("snan", 0, 0);
    elems = '{32'h7FC00001, 32'hFFC00000}; useLast = 1; modeBit = 0;
    applyStimulus("bothnan", 0, 0);
    elems = '{32'h00000000, 32'h80000000}; useLast = 1; modeBit = 0;
    applyStimulus("zeros", 0, 0);
    elems = '{32'h40400000, 32'h3F800000, 32'h40800000}; useLast = 1; modeBit = 1;
    applyStimulus("hold3", 3, 0);
    elems = '{32'hFF800001}; useLast = 1; modeBit = 0;
    applyStimulus("single", 1, 0);

    // Abort a stream halfway, then the next one must index from zero.
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 32'h3F000000 + 32'(i); in_last = 1'b0; in_mode = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checkResetState("rstmid");
    rst = 1'b0;
    elems = '{32'h40A00000, 32'h3F800000}; useLast = 1; modeBit = 0;
    applyStimulus("afterrst", 0, 0);

    // Reset while a result is held discards it.
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'h40000000; in_last = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    checkVal("rstdone_pre_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    checkResetState("rstdone");
    rst = 1'b0; out_ready = 1'b1;

    // Truncation on the MAX_LEN=4 instance.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in4Valid = 1'b1; in4Last = 1'b0; in4Mode = (i == 0) ? 1'b1 : 1'b0;
      case (i)
        0: in4Data = 32'h3F800000;
        1: in4Data = 32'h40000000;
        2: in4Data = 32'h7F800000;
        default: in4Data = 32'h40400000;
      endcase
    end
    @(negedge clk);
    in4Valid = 1'b0;
    checkVal("trunc_valid", 32'(out4Valid), 32'd1);
    checkVal("trunc_rdy", 32'(in4Ready), 32'd0);
    checkVal("trunc_data", out4Data, 32'h7F800000);
    checkVal("trunc_idx", 32'(out4Idx), 32'd2);
    checkVal("trunc_flag", 32'(out4Trunc), 32'd1);
    checkVal("trunc_status", 32'(out4Status), 32'd0);
    out4Ready = 1'b1;
    @(negedge clk);
    checkVal("trunc_rel_valid", 32'(out4Valid), 32'd0);

    for (int s = 0; s < 40; s++) begin
      int n;
      elems.delete();
      n = $urandom_range(1, 16);
      repeat (n) elems.push_back(randElem());
      useLast = (n < 16) ? 1'b1 : 1'($urandom);
      modeBit = 1'($urandom);
      applyStimulus("rnd", $urandom_range(0, 3), 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
